scaler_line_pack: RTL and testbench
===================================

Name: scaler_line_pack

Overview:
- Downstream of the vertical scaler. Takes its sparse pixel stream (idle cycles between pixels, hs/vs qualified by de on the first pixel) and stores each line in a 2-bank ping-pong line buffer.
- Re-emits every stored line as a dense burst: de continuous for the whole line, a programmable blank gap between lines.
- Feeds the video output/timing stage.

Parameters:
- DATA_WIDTH, 8, pixel width.
- LINE_SIZE_MAX, 1024, buffer depth per bank in pixels.
- HBLANK_CYCLES, 16, idle cycles inserted after each output line (0 allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-low.
- line_size  in  16  pixels per line minus 1. Sampled at each input hs.
- di_i  in  DATA_WIDTH  input pixel.
- de_i  in  1  input pixel valid.
- hs_i  in  1  first pixel of line. Qualified by de_i.
- vs_i  in  1  first pixel of frame. Qualified by de_i; hs_i is also high on that pixel.
- do_o  out  DATA_WIDTH  output pixel.
- de_o  out  1  output pixel valid.
- hs_o  out  1  first pixel of output line. Qualified by de_o.
- vs_o  out  1  first pixel of output frame. Qualified by de_o.
- ovf_o  out  1  one-cycle pulse: an input line was dropped.
- err_o  out  1  one-cycle pulse: excess pixel discarded.

Behaviour:
- Reset (rst=0 at a clk edge):
  - do_o=0, de_o=hs_o=vs_o=ovf_o=err_o=0.
  - Both bank-full flags cleared; wr_bank=rd_bank=0; FSM to IDLE; write count 0.
  - Buffer contents are not cleared.
  - Reset mid-line or mid-output aborts immediately; no partial line is emitted afterwards.
- Write side (only on cycles with de_i=1):
  - hs_i=1: latch line_size into lsz_wr, write pixel to address 0, wcnt<=1, capture vs_i into vsflag[wr_bank].
    - If full[wr_bank]=1 at that hs, the whole line is dropped: no writes until the next hs, ovf_o pulses on the cycle after the hs.
  - hs_i=0: write to address wcnt, wcnt+1.
  - Line completes when the pixel at address lsz_wr is written. Next cycle: full[wr_bank]<=1, lsz[wr_bank]<=lsz_wr, wr_bank toggles.
  - Pixels after completion and before the next hs are discarded; err_o pulses once per discarded pixel.
  - de_i without a preceding hs since reset is discarded, with no err.
  - line_size >= LINE_SIZE_MAX is clamped to LINE_SIZE_MAX-1.
- Read FSM:
  - IDLE: when full[rd_bank]=1, go to LINE_OUT with raddr=0.
  - LINE_OUT: raddr increments every cycle. After issuing raddr==lsz[rd_bank], go to HBLANK, or RELEASE if HBLANK_CYCLES=0.
  - HBLANK: count HBLANK_CYCLES cycles, then RELEASE.
  - RELEASE (1 cycle): full[rd_bank]<=0, rd_bank toggles, go to IDLE.
  - Minimum line period = lsz+1 + HBLANK_CYCLES + 2 cycles.
- Output timing:
  - The RAM read is registered, then the output is registered: address issued in cycle n appears on do_o/de_o in cycle n+2.
  - hs_o=1 with the pixel from address 0. vs_o=1 on that pixel only when vsflag[rd_bank]=1.
  - de_o is continuous for lsz+1 cycles per line, with no gaps.
  - Latency: line-complete cycle c gives the first de_o at c+4 when the FSM was IDLE (full set c+1, LINE_OUT c+2, data c+4).
- Simultaneous events:
  - Write completion setting full[wr_bank] and RELEASE clearing full[rd_bank] in the same cycle: both take effect, since they are distinct banks.
  - If wr_bank==rd_bank, set and clear cannot coincide by construction.
  - An hs arriving in the same cycle RELEASE clears that bank's flag sees the pre-release value and drops the line. Documented, intentional.
- Throughput: sustains any input with average pixel rate <= 1 per cycle, provided input line period >= output line period.

Test Plan:
- Dense single line: line_size=7, pixels 0..7 sparse with 2 idle cycles each, HBLANK_CYCLES=4 -> de_o high 8 consecutive cycles, do_o=0..7, hs_o on the first pixel only, first de_o 4 cycles after the last input pixel.
- Frame start: vs_i+hs_i on line 0, then 2 more lines of 4 pixels (line_size=3) -> vs_o only on the first pixel of line 0; hs_o on 3 line starts; data order intact.
- Overflow: HBLANK_CYCLES=100, three back-to-back dense 4-pixel lines -> lines 0 and 1 output, line 2 dropped, ovf_o single pulse the cycle after the third hs, no err_o.
- Excess pixels: line_size=3, 6 pixels before the next hs -> 4 pixels output, err_o pulses twice.
- Reset mid-output: rst=0 during the 3rd output pixel of a 16-pixel line -> de_o=0 the next cycle, full flags cleared; a new line after reset outputs correctly from bank 0.
- HBLANK_CYCLES=0 with 2 queued lines of 8 -> gap between bursts exactly 2 cycles (RELEASE+IDLE); values correct.

Source files
------------

// File: rtl/scaler_line_pack.sv
// scaler_line_pack: stores sparse scaler lines in a 2-bank ping-pong
// buffer and replays each one as a dense burst plus a blank gap.
// Ports: clk, rst (sync, active-low), line_size (pixels-1),
//   di_i/de_i/hs_i/vs_i sparse input; do_o/de_o/hs_o/vs_o dense output;
//   ovf_o pulse when an input line is dropped, err_o per excess pixel.
module scaler_line_pack #(
  parameter int DATA_WIDTH    = 8,
  parameter int LINE_SIZE_MAX = 1024,
  parameter int HBLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           line_size,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  ovf_o,
  output logic                  err_o
);

  localparam int AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
  localparam int HW = (HBLANK_CYCLES > 1) ? $clog2(HBLANK_CYCLES) : 1;
  localparam logic [AW-1:0] LSZ_TOP = AW'(LINE_SIZE_MAX - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(HBLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_HBLANK,
    S_REL
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [2][LINE_SIZE_MAX];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic [1:0]    vsflag_q;
  logic [AW-1:0] lsz_q [2];
  logic [AW-1:0] lsz_wr_q;
  logic [AW-1:0] wcnt_q;
  logic          wr_act_q;
  logic          drop_q;
  logic          seen_q;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] raddr_d;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_d;
  logic          rel;
  logic          issue;
  logic          v1_q;
  logic          h1_q;
  logic          s1_q;

  logic [AW-1:0] lsz_in;
  logic          hs_ok;
  logic          we;
  logic [AW-1:0] waddr;
  logic          cmp;
  logic [AW-1:0] cmp_lsz;

  // Oversized requests are clamped to the bank depth.
  always_comb begin
    lsz_in = line_size[AW-1:0];
    if ({16'd0, line_size} >= 32'(LINE_SIZE_MAX)) begin
      lsz_in = LSZ_TOP;
    end
  end

  // An hs into a still-full bank drops the whole line.
  assign hs_ok = de_i & hs_i & ~full_q[wr_bank_q];
  assign we    = hs_ok | (de_i & ~hs_i & wr_act_q);
  assign waddr = hs_i ? '0 : wcnt_q;

  assign cmp = (hs_ok & (lsz_in == '0))
             | (de_i & ~hs_i & wr_act_q & (wcnt_q == lsz_wr_q));
  assign cmp_lsz = hs_i ? lsz_in : lsz_wr_q;

  // Set and clear always target distinct banks when they coincide.
  always_comb begin
    full_d = full_q;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (cmp) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      vsflag_q  <= 2'b00;
      lsz_q[0]  <= '0;
      lsz_q[1]  <= '0;
      lsz_wr_q  <= '0;
      wcnt_q    <= '0;
      wr_act_q  <= 1'b0;
      drop_q    <= 1'b0;
      seen_q    <= 1'b0;
      ovf_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      ovf_o  <= 1'b0;
      err_o  <= 1'b0;
      full_q <= full_d;
      if (cmp) begin
        lsz_q[wr_bank_q] <= cmp_lsz;
        wr_bank_q        <= ~wr_bank_q;
      end
      if (de_i) begin
        if (hs_i) begin
          seen_q <= 1'b1;
          if (full_q[wr_bank_q]) begin
            drop_q   <= 1'b1;
            wr_act_q <= 1'b0;
            ovf_o    <= 1'b1;
          end else begin
            drop_q              <= 1'b0;
            lsz_wr_q            <= lsz_in;
            wcnt_q              <= AW'(1);
            vsflag_q[wr_bank_q] <= vs_i;
            wr_act_q            <= (lsz_in != '0);
          end
        end else if (wr_act_q) begin
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == lsz_wr_q) begin
            wr_act_q <= 1'b0;
          end
        end else if (seen_q && !drop_q) begin
          err_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_bank_q][waddr] <= di_i;
    end
    rdata_q <= mem_q[rd_bank_q][raddr_q];
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    hcnt_d  = hcnt_q;
    rel     = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_LINE;
          raddr_d = '0;
        end
      end
      S_LINE: begin
        issue = 1'b1;
        if (raddr_q == lsz_q[rd_bank_q]) begin
          hcnt_d  = '0;
          state_d = (HBLANK_CYCLES == 0) ? S_REL : S_HBLANK;
        end else begin
          raddr_d = raddr_q + 1'b1;
        end
      end
      S_HBLANK: begin
        if (hcnt_q == HB_LAST) begin
          state_d = S_REL;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_REL: begin
        rel     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address in cycle n -> RAM data n+1 -> output register n+2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      raddr_q   <= '0;
      hcnt_q    <= '0;
      rd_bank_q <= 1'b0;
      v1_q      <= 1'b0;
      h1_q      <= 1'b0;
      s1_q      <= 1'b0;
      do_o      <= '0;
      de_o      <= 1'b0;
      hs_o      <= 1'b0;
      vs_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      hcnt_q  <= hcnt_d;
      if (rel) begin
        rd_bank_q <= ~rd_bank_q;
      end
      v1_q <= issue;
      h1_q <= issue & (raddr_q == '0);
      s1_q <= issue & (raddr_q == '0) & vsflag_q[rd_bank_q];
      do_o <= v1_q ? rdata_q : '0;
      de_o <= v1_q;
      hs_o <= h1_q;
      vs_o <= s1_q;
    end
  end

endmodule

// File: tb/tb_scaler_line_pack.sv
// tb_scaler_line_pack: directed bench for scaler_line_pack using
// three instances with HBLANK_CYCLES of 4, 100 and 0.
module tb_scaler_line_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] line_size = '0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;

  logic [7:0] a_do, b_do, c_do;
  logic a_de, a_hs, a_vs, a_ovf, a_err;
  logic b_de, b_hs, b_vs, b_ovf, b_err;
  logic c_de, c_hs, c_vs, c_ovf, c_err;

  scaler_line_pack #(.DATA_WIDTH(8), .LINE_SIZE_MAX(1024),
    .HBLANK_CYCLES(4)) u_h4 (
    .clk(clk), .rst(rst), .line_size(line_size),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(a_do), .de_o(a_de), .hs_o(a_hs), .vs_o(a_vs),
    .ovf_o(a_ovf), .err_o(a_err));

  scaler_line_pack #(.DATA_WIDTH(8), .LINE_SIZE_MAX(1024),
    .HBLANK_CYCLES(100)) u_h100 (
    .clk(clk), .rst(rst), .line_size(line_size),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(b_do), .de_o(b_de), .hs_o(b_hs), .vs_o(b_vs),
    .ovf_o(b_ovf), .err_o(b_err));

  scaler_line_pack #(.DATA_WIDTH(8), .LINE_SIZE_MAX(1024),
    .HBLANK_CYCLES(0)) u_h0 (
    .clk(clk), .rst(rst), .line_size(line_size),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(c_do), .de_o(c_de), .hs_o(c_hs), .vs_o(c_vs),
    .ovf_o(c_ovf), .err_o(c_err));

  typedef struct {
    logic [7:0] d;
    logic       hs;
    logic       vs;
    int         cyc;
  } px_t;

  px_t qa[$];
  px_t qb[$];
  px_t qc[$];
  int ovfa, erra, ovfb, errb, ovfb_cyc, ovfc, errc;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int last_in;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    px_t p;
    if (a_de) begin
      p.d = a_do; p.hs = a_hs; p.vs = a_vs; p.cyc = cyc;
      qa.push_back(p);
    end
    if (b_de) begin
      p.d = b_do; p.hs = b_hs; p.vs = b_vs; p.cyc = cyc;
      qb.push_back(p);
    end
    if (c_de) begin
      p.d = c_do; p.hs = c_hs; p.vs = c_vs; p.cyc = cyc;
      qc.push_back(p);
    end
    if (a_ovf) ovfa++;
    if (a_err) erra++;
    if (b_ovf) begin ovfb++; ovfb_cyc = cyc; end
    if (b_err) errb++;
    if (c_ovf) ovfc++;
    if (c_err) errc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    qa.delete(); qb.delete(); qc.delete();
    ovfa = 0; erra = 0; ovfb = 0; errb = 0;
    ovfb_cyc = -1; ovfc = 0; errc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    clr();
  endtask

  task automatic px(input logic [7:0] d, input logic h,
                    input logic v, input int gap);
    di_i = d; de_i = 1'b1; hs_i = h; vs_i = v;
    last_in = cyc;
    tick();
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_do !== 8'h00) begin
      fails++; $display("FAIL reset_do got %0h want 0", a_do);
    end
    checks++;
    if ({a_de, a_hs, a_vs} !== 3'b000) begin
      fails++; $display("FAIL reset_de_hs_vs got %b want 000",
                        {a_de, a_hs, a_vs});
    end
    checks++;
    if ({a_ovf, a_err} !== 2'b00) begin
      fails++; $display("FAIL reset_ovf_err got %b want 00",
                        {a_ovf, a_err});
    end
    checks++;
    if ({b_de, c_de} !== 2'b00) begin
      fails++; $display("FAIL reset_de_other got %b want 00",
                        {b_de, c_de});
    end
  endtask

  task automatic test_dense_line();
    do_reset();
    line_size = 16'd7;
    for (int i = 0; i < 8; i++) px(8'(i), i == 0, 1'b0, 2);
    repeat (30) tick();
    checks++;
    if (qa.size() != 8) begin
      fails++; $display("FAIL dense_count got %0d want 8", qa.size());
    end
    for (int i = 0; i < 8 && i < qa.size(); i++) begin
      checks++;
      if (qa[i].d !== 8'(i) || qa[i].hs !== (i == 0) ||
          qa[i].vs !== 1'b0) begin
        fails++;
        $display("FAIL dense_px%0d got d=%0h hs=%b vs=%b want d=%0h hs=%b vs=0",
                 i, qa[i].d, qa[i].hs, qa[i].vs, i, i == 0);
      end
      checks++;
      if (qa[i].cyc != last_in + 4 + i) begin
        fails++;
        $display("FAIL dense_time%0d got %0d want %0d",
                 i, qa[i].cyc, last_in + 4 + i);
      end
    end
    checks++;
    if (erra != 0 || ovfa != 0) begin
      fails++; $display("FAIL dense_flags got err=%0d ovf=%0d want 0 0",
                        erra, ovfa);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    line_size = 16'd3;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++)
        px(8'(32 + l * 4 + i), i == 0, (l == 0) && (i == 0), 2);
    repeat (40) tick();
    checks++;
    if (qa.size() != 12) begin
      fails++; $display("FAIL frame_count got %0d want 12", qa.size());
    end
    for (int i = 0; i < 12 && i < qa.size(); i++) begin
      checks++;
      if (qa[i].d !== 8'(32 + i) || qa[i].hs !== (i % 4 == 0) ||
          qa[i].vs !== (i == 0)) begin
        fails++;
        $display("FAIL frame_px%0d got d=%0h hs=%b vs=%b want d=%0h hs=%b vs=%b",
                 i, qa[i].d, qa[i].hs, qa[i].vs, 32 + i,
                 i % 4 == 0, i == 0);
      end
    end
    checks++;
    if (erra != 0 || ovfa != 0) begin
      fails++; $display("FAIL frame_flags got err=%0d ovf=%0d want 0 0",
                        erra, ovfa);
    end
  endtask

  task automatic test_overflow();
    int h2;
    do_reset();
    line_size = 16'd3;
    h2 = -1;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++) begin
        if (l == 2 && i == 0) h2 = cyc;
        px(8'(48 + l * 4 + i), i == 0, 1'b0, 0);
      end
    repeat (260) tick();
    checks++;
    if (qb.size() != 8) begin
      fails++; $display("FAIL ovf_count got %0d want 8", qb.size());
    end
    for (int i = 0; i < 8 && i < qb.size(); i++) begin
      checks++;
      if (qb[i].d !== 8'(48 + i) || qb[i].hs !== (i % 4 == 0)) begin
        fails++;
        $display("FAIL ovf_px%0d got d=%0h hs=%b want d=%0h hs=%b",
                 i, qb[i].d, qb[i].hs, 48 + i, i % 4 == 0);
      end
    end
    checks++;
    if (ovfb != 1) begin
      fails++; $display("FAIL ovf_pulses got %0d want 1", ovfb);
    end
    checks++;
    if (ovfb_cyc != h2 + 1) begin
      fails++; $display("FAIL ovf_time got %0d want %0d",
                        ovfb_cyc, h2 + 1);
    end
    checks++;
    if (errb != 0) begin
      fails++; $display("FAIL ovf_err got %0d want 0", errb);
    end
  endtask

  task automatic test_excess();
    do_reset();
    line_size = 16'd3;
    for (int i = 0; i < 6; i++) px(8'(80 + i), i == 0, 1'b0, 1);
    repeat (30) tick();
    checks++;
    if (qa.size() != 4) begin
      fails++; $display("FAIL excess_count got %0d want 4", qa.size());
    end
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      checks++;
      if (qa[i].d !== 8'(80 + i)) begin
        fails++; $display("FAIL excess_px%0d got %0h want %0h",
                          i, qa[i].d, 80 + i);
      end
    end
    checks++;
    if (erra != 2) begin
      fails++; $display("FAIL excess_err got %0d want 2", erra);
    end
    checks++;
    if (ovfa != 0) begin
      fails++; $display("FAIL excess_ovf got %0d want 0", ovfa);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit found;
    do_reset();
    line_size = 16'd15;
    for (int i = 0; i < 16; i++) px(8'(64 + i), i == 0, 1'b0, 0);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (a_de) begin
        cnt++;
        if (cnt == 3) found = 1'b1;
      end
      if (!found) tick();
    end
    checks++;
    if (!found) begin
      fails++; $display("FAIL rstmid_wait got %0d pixels want 3", cnt);
    end
    checks++;
    if (a_do !== 8'h42) begin
      fails++; $display("FAIL rstmid_px3 got %0h want 42", a_do);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({a_de, a_hs, a_do} !== 10'd0) begin
      fails++; $display("FAIL rstmid_cut got de=%b hs=%b do=%0h want 0",
                        a_de, a_hs, a_do);
    end
    rst = 1'b1;
    repeat (60) tick();
    checks++;
    if (qa.size() != 3) begin
      fails++; $display("FAIL rstmid_nopartial got %0d want 3", qa.size());
    end
    clr();
    line_size = 16'd3;
    for (int i = 0; i < 4; i++) px(8'(96 + i), i == 0, 1'b0, 0);
    repeat (20) tick();
    checks++;
    if (qa.size() != 4) begin
      fails++; $display("FAIL rstmid_new_count got %0d want 4", qa.size());
    end
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      checks++;
      if (qa[i].d !== 8'(96 + i) || qa[i].hs !== (i == 0) ||
          qa[i].cyc != last_in + 4 + i) begin
        fails++;
        $display("FAIL rstmid_new%0d got d=%0h hs=%b t=%0d want d=%0h hs=%b t=%0d",
                 i, qa[i].d, qa[i].hs, qa[i].cyc, 96 + i, i == 0,
                 last_in + 4 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int exp_t;
    do_reset();
    line_size = 16'd7;
    c0 = -1;
    for (int i = 0; i < 16; i++) begin
      px(8'(112 + i), i % 8 == 0, 1'b0, 0);
      if (i == 7) c0 = last_in;
    end
    repeat (40) tick();
    checks++;
    if (qc.size() != 16) begin
      fails++; $display("FAIL b2b_count got %0d want 16", qc.size());
    end
    for (int i = 0; i < 16 && i < qc.size(); i++) begin
      exp_t = (i < 8) ? c0 + 4 + i : c0 + 14 + (i - 8);
      checks++;
      if (qc[i].d !== 8'(112 + i) || qc[i].hs !== (i % 8 == 0) ||
          qc[i].cyc != exp_t) begin
        fails++;
        $display("FAIL b2b_px%0d got d=%0h hs=%b t=%0d want d=%0h hs=%b t=%0d",
                 i, qc[i].d, qc[i].hs, qc[i].cyc, 112 + i,
                 i % 8 == 0, exp_t);
      end
    end
    checks++;
    if (qc.size() == 16 && qc[8].cyc - qc[7].cyc != 3) begin
      fails++; $display("FAIL b2b_gap got %0d want 2",
                        qc[8].cyc - qc[7].cyc - 1);
    end
  endtask

  task automatic test_clamp();
    int bad;
    do_reset();
    line_size = 16'hFFFF;
    for (int i = 0; i < 1025; i++) px(8'(i), i == 0, 1'b0, 0);
    repeat (1040) tick();
    checks++;
    if (qa.size() != 1024) begin
      fails++; $display("FAIL clamp_count got %0d want 1024", qa.size());
    end
    bad = 0;
    for (int i = 0; i < 1024 && i < qa.size(); i++)
      if (qa[i].d !== 8'(i) || qa[i].hs !== (i == 0)) bad++;
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL clamp_data got %0d bad pixels want 0", bad);
    end
    checks++;
    if (erra != 1) begin
      fails++; $display("FAIL clamp_err got %0d want 1", erra);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_dense_line();
    test_frame_start();
    test_overflow();
    test_excess();
    test_reset_mid();
    test_back_to_back();
    test_clamp();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
